// File: rtl/puf_spi_engine.sv
// Challenge/response engine: fetches a challenge byte over SPI, expands it with an LFSR-based
// PUF model, checks the response popcount against a window and reports pass/fail over SPI.
module puf_spi_engine #(
    parameter int unsigned CLKS_PER_HALF_BIT = 2,
    parameter int unsigned RESP_W            = 256,
    parameter int unsigned POP_MIN           = 96,
    parameter int unsigned POP_MAX           = 160,
    parameter logic [7:0]  REQ_BYTE          = 8'h01,
    parameter logic [7:0]  PASS_BYTE         = 8'h55,
    parameter logic [7:0]  FAIL_BYTE         = 8'hAA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              spi_miso,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        challenge,
    output logic [RESP_W-1:0] response
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_HALF_BIT + 1);
    localparam int unsigned STEP_W = $clog2(RESP_W + 1);
    localparam int unsigned ONES_W = $clog2(RESP_W + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RESP_W - 1);
    localparam logic [31:0]       LFSR_TAPS = 32'h80200003;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHALL  = 3'd1;
    localparam logic [2:0] ST_EVAL   = 3'd2;
    localparam logic [2:0] ST_REPORT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [2:0] SP_IDLE  = 3'd0;
    localparam logic [2:0] SP_SETUP = 3'd1;
    localparam logic [2:0] SP_BITS  = 3'd2;
    localparam logic [2:0] SP_HOLD  = 3'd3;
    localparam logic [2:0] SP_GAP   = 3'd4;

    logic [2:0]        state;
    logic [2:0]        sp_phase;
    logic [CNT_W-1:0]  half_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;
    logic              byte_go;
    logic [7:0]        byte_tx;
    logic              byte_done;

    logic [31:0]       lfsr;
    logic [31:0]       lfsr_next;
    logic [STEP_W-1:0] step;
    logic [ONES_W-1:0] ones;
    logic [ONES_W-1:0] ones_final;
    logic [31:0]       ones_ext;
    logic              pass_next;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
        ones_final = ones + ONES_W'(lfsr_next[0]);
        ones_ext   = 32'(ones_final);
        pass_next  = (ones_ext >= POP_MIN) && (ones_ext <= POP_MAX);
    end

    // SPI byte engine, mode 0: setup half period, 8 SCLK periods, hold, then a cs_n-high gap.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_phase  <= SP_IDLE;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_cs_n  <= 1'b1;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            case (sp_phase)
                SP_IDLE: begin
                    if (byte_go) begin
                        spi_cs_n <= 1'b0;
                        spi_mosi <= byte_tx[7];
                        tx_sh    <= byte_tx;
                        half_cnt <= '0;
                        bit_cnt  <= '0;
                        sp_phase <= SP_SETUP;
                    end
                end
                SP_SETUP: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        spi_sclk <= 1'b1;
                        rx_sh    <= {rx_sh[6:0], spi_miso};
                        sp_phase <= SP_BITS;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                SP_BITS: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        if (spi_sclk) begin
                            spi_sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                sp_phase <= SP_HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                spi_mosi <= tx_sh[6];
                                tx_sh    <= {tx_sh[6:0], 1'b0};
                            end
                        end else begin
                            spi_sclk <= 1'b1;
                            rx_sh    <= {rx_sh[6:0], spi_miso};
                        end
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                SP_HOLD: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt <= '0;
                        spi_cs_n <= 1'b1;
                        spi_mosi <= 1'b0;
                        sp_phase <= SP_GAP;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                SP_GAP: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt  <= '0;
                        byte_done <= 1'b1;
                        sp_phase  <= SP_IDLE;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                end
                default: sp_phase <= SP_IDLE;
            endcase
        end
    end

    // Transaction sequencer; response shifts in MSB first so step k lands at bit RESP_W-1-k.
    // NOTE: the response register is a flop bank, not a RAM, so it takes the reset like any other state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            challenge <= '0;
            response  <= '0;
            lfsr      <= '0;
            step      <= '0;
            ones      <= '0;
            byte_go   <= 1'b0;
            byte_tx   <= '0;
        end else begin
            byte_go <= 1'b0;
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        byte_go <= 1'b1;
                        byte_tx <= REQ_BYTE;
                        state   <= ST_CHALL;
                    end
                end
                ST_CHALL: begin
                    if (byte_done) begin
                        challenge <= rx_sh;
                        lfsr      <= {rx_sh, ~rx_sh, rx_sh, 8'hA5};
                        step      <= '0;
                        ones      <= '0;
                        state     <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    lfsr     <= lfsr_next;
                    response <= {response[RESP_W-2:0], lfsr_next[0]};
                    ones     <= ones_final;
                    if (step == STEP_LAST) begin
                        pass    <= pass_next;
                        byte_go <= 1'b1;
                        byte_tx <= pass_next ? PASS_BYTE : FAIL_BYTE;
                        state   <= ST_REPORT;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (byte_done) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_spi_engine.sv
// Scoreboard bench for puf_spi_engine: three instances differing only in popcount window,
// driven by one SPI slave model; expected windows and transactions are queued at launch.
module tb_puf_spi_engine;

    localparam int          CPHB = 2;
    localparam logic [7:0]  REQ  = 8'h01;
    localparam logic [31:0] TAPS = 32'h80200003;

    typedef struct {
        logic [7:0] m_dut;
        logic [7:0] m_pass;
        logic [7:0] m_fail;
    } win_t;

    typedef struct {
        logic [7:0]   chal;
        logic [255:0] resp;
        logic         pass;
    } txn_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         miso = 1'b0;
    logic [7:0]   slave_byte = 8'h00;

    logic         sclk_d, mosi_d, cs_n_d, busy_d, done_d, pass_d;
    logic [7:0]   chal_d;
    logic [255:0] resp_d;
    logic         sclk_p, mosi_p, cs_n_p, busy_p, done_p, pass_p;
    logic [7:0]   chal_p;
    logic [255:0] resp_p;
    logic         sclk_f, mosi_f, cs_n_f, busy_f, done_f, pass_f;
    logic [7:0]   chal_f;
    logic [255:0] resp_f;

    int n_checks = 0;
    int n_fails  = 0;
    int win_cnt  = 0;
    int cyc      = 0;

    win_t exp_win[$];
    txn_t exp_txn[$];

    always #5 clk = ~clk;

    puf_spi_engine u_dut (
        .clk(clk), .reset(reset), .start(start), .spi_miso(miso),
        .spi_sclk(sclk_d), .spi_mosi(mosi_d), .spi_cs_n(cs_n_d),
        .busy(busy_d), .done(done_d), .pass(pass_d),
        .challenge(chal_d), .response(resp_d)
    );

    puf_spi_engine #(.POP_MIN(0), .POP_MAX(256)) u_pass (
        .clk(clk), .reset(reset), .start(start), .spi_miso(miso),
        .spi_sclk(sclk_p), .spi_mosi(mosi_p), .spi_cs_n(cs_n_p),
        .busy(busy_p), .done(done_p), .pass(pass_p),
        .challenge(chal_p), .response(resp_p)
    );

    puf_spi_engine #(.POP_MIN(257)) u_fail (
        .clk(clk), .reset(reset), .start(start), .spi_miso(miso),
        .spi_sclk(sclk_f), .spi_mosi(mosi_f), .spi_cs_n(cs_n_f),
        .busy(busy_f), .done(done_f), .pass(pass_f),
        .challenge(chal_f), .response(resp_f)
    );

    function automatic void model(input logic [7:0] c, output logic [255:0] r, output int pop);
        logic [31:0] l;
        logic        lsb;
        l   = {c, ~c, c, 8'hA5};
        pop = 0;
        r   = '0;
        for (int k = 0; k < 256; k++) begin
            lsb = l[0];
            l   = l >> 1;
            if (lsb) l = l ^ TAPS;
            r[255-k] = l[0];
            pop += int'(l[0]);
        end
    endfunction

    // SPI slave model and bus monitor, evaluated on the falling clk edge.
    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;
    logic [7:0] slv_sh = 8'h00;
    logic [7:0] sh_d = 8'h00, sh_p = 8'h00, sh_f = 8'h00;
    int         rises = 0;
    int         last_rise = 0;
    win_t       w;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            miso  = 1'b0;
            rises = 0;
        end else begin
            if (prev_cs && !cs_n_d) begin
                rises  = 0;
                slv_sh = slave_byte;
                miso   = slv_sh[7];
            end
            if (!cs_n_d && !prev_sclk && sclk_d) begin
                sh_d = {sh_d[6:0], mosi_d};
                sh_p = {sh_p[6:0], mosi_p};
                sh_f = {sh_f[6:0], mosi_f};
                if (rises > 0) begin
                    n_checks++;
                    if (cyc - last_rise !== 2 * CPHB) begin
                        n_fails++;
                        $display("FAIL sclk_period got=%0d exp=%0d", cyc - last_rise, 2 * CPHB);
                    end
                end
                last_rise = cyc;
                rises++;
            end
            if (!cs_n_d && prev_sclk && !sclk_d) begin
                slv_sh = {slv_sh[6:0], 1'b0};
                miso   = slv_sh[7];
            end
            if (!prev_cs && cs_n_d) begin
                win_cnt++;
                miso = 1'b0;
                n_checks++;
                if (rises !== 8) begin
                    n_fails++;
                    $display("FAIL sclk_rises_per_window got=%0d exp=8", rises);
                end
                n_checks++;
                if (exp_win.size() == 0) begin
                    n_fails++;
                    $display("FAIL unexpected_cs_window got=1 exp=0");
                end else begin
                    w = exp_win.pop_front();
                    if (sh_d !== w.m_dut || sh_p !== w.m_pass || sh_f !== w.m_fail) begin
                        n_fails++;
                        $display("FAIL mosi_byte got=%h/%h/%h exp=%h/%h/%h",
                                 sh_d, sh_p, sh_f, w.m_dut, w.m_pass, w.m_fail);
                    end
                end
            end
        end
        prev_cs   = cs_n_d;
        prev_sclk = sclk_d;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(input logic [7:0] c);
        txn_t         t;
        win_t         w1;
        win_t         w2;
        logic [255:0] r;
        int           pop;
        model(c, r, pop);
        t.chal = c;
        t.resp = r;
        t.pass = (pop >= 96) && (pop <= 160);
        w1 = '{m_dut: REQ, m_pass: REQ, m_fail: REQ};
        w2 = '{m_dut: (t.pass ? 8'h55 : 8'hAA), m_pass: 8'h55, m_fail: 8'hAA};
        exp_txn.push_back(t);
        exp_win.push_back(w1);
        exp_win.push_back(w2);
        slave_byte = c;
        pulse_start();
    endtask

    task automatic wait_done(input int extra_start_at);
        bit   seen = 0;
        bit   busy_ok = 1;
        bit   sync_ok = 1;
        int   extra_done = 0;
        txn_t t;
        for (int i = 1; i < 2000 && !seen; i++) begin
            start = (extra_start_at != 0 && i == extra_start_at);
            @(negedge clk);
            if (done_d === 1'b1) begin
                seen = 1;
                if (busy_d !== 1'b0) busy_ok = 0;
                if (done_p !== 1'b1 || done_f !== 1'b1) sync_ok = 0;
            end else if (busy_d !== 1'b1) begin
                busy_ok = 0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fails++;
            $display("FAIL done_timeout got=0 exp=1");
        end
        n_checks++;
        if (!busy_ok) begin
            n_fails++;
            $display("FAIL busy_window got=bad exp=high_until_done");
        end
        n_checks++;
        if (!sync_ok) begin
            n_fails++;
            $display("FAIL done_all_instances got=%b%b exp=11", done_p, done_f);
        end
        n_checks++;
        if (exp_txn.size() == 0) begin
            n_fails++;
            $display("FAIL txn_queue_empty got=0 exp=1");
        end else begin
            t = exp_txn.pop_front();
            if (chal_d !== t.chal) begin
                n_fails++;
                $display("FAIL challenge got=%h exp=%h", chal_d, t.chal);
            end
            n_checks++;
            if (resp_d !== t.resp) begin
                n_fails++;
                $display("FAIL response got=%h exp=%h", resp_d, t.resp);
            end
            n_checks++;
            if (pass_d !== t.pass || pass_p !== 1'b1 || pass_f !== 1'b0) begin
                n_fails++;
                $display("FAIL pass got=%b%b%b exp=%b10", pass_d, pass_p, pass_f, t.pass);
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_d !== 1'b0 || busy_d !== 1'b0) extra_done++;
        end
        n_checks++;
        if (extra_done != 0) begin
            n_fails++;
            $display("FAIL single_done_pulse got=%0d exp=0", extra_done);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input bit full);
        n_checks++;
        if (cs_n_d !== 1'b1 || sclk_d !== 1'b0 || busy_d !== 1'b0 || done_d !== 1'b0) begin
            n_fails++;
            $display("FAIL %s_bus got=cs%b sclk%b busy%b done%b exp=cs1 sclk0 busy0 done0",
                     tag, cs_n_d, sclk_d, busy_d, done_d);
        end
        if (full) begin
            n_checks++;
            if (mosi_d !== 1'b0 || pass_d !== 1'b0 || chal_d !== 8'h00 || resp_d !== '0) begin
                n_fails++;
                $display("FAIL %s_regs got=mosi%b pass%b chal%h resp%h exp=zero",
                         tag, mosi_d, pass_d, chal_d, resp_d);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("post_reset", 1);
    endtask

    task automatic test_basic();
        launch(8'h3C);
        wait_done(0);
    endtask

    task automatic test_spi_timing();
        int w0 = win_cnt;
        launch(8'hA5);
        wait_done(0);
        n_checks++;
        if (win_cnt - w0 !== 2) begin
            n_fails++;
            $display("FAIL window_count got=%0d exp=2", win_cnt - w0);
        end
    endtask

    task automatic test_start_during_eval();
        int w0 = win_cnt;
        int late_done = 0;
        launch(8'h5A);
        wait_done(150);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_d !== 1'b0 || busy_d !== 1'b0) late_done++;
        end
        n_checks++;
        if (late_done != 0 || win_cnt - w0 !== 2) begin
            n_fails++;
            $display("FAIL start_in_eval got=late%0d win%0d exp=late0 win2", late_done, win_cnt - w0);
        end
    endtask

    task automatic test_reset_mid_chall();
        slave_byte = 8'h11;
        pulse_start();
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_chall", 0);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_mid_chall_held", 1);
        reset = 1'b0;
        exp_win.delete();
        exp_txn.delete();
        repeat (3) @(negedge clk);
        launch(8'hC3);
        wait_done(0);
    endtask

    task automatic test_reset_mid_eval();
        win_t w1;
        w1 = '{m_dut: REQ, m_pass: REQ, m_fail: REQ};
        exp_win.push_back(w1);
        slave_byte = 8'h77;
        pulse_start();
        repeat (100) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_eval", 0);
        n_checks++;
        if (exp_win.size() != 0) begin
            n_fails++;
            $display("FAIL reset_mid_eval_window got=%0d exp=0", exp_win.size());
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_win.delete();
        exp_txn.delete();
        repeat (3) @(negedge clk);
        launch(8'h77);
        wait_done(0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] c;
        launch(8'h00);
        wait_done(0);
        launch(8'hFF);
        wait_done(0);
        for (int i = 0; i < 3; i++) begin
            c = 8'($urandom_range(0, 255));
            launch(c);
            wait_done(0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spi_timing();
        test_start_during_eval();
        test_reset_mid_chall();
        test_reset_mid_eval();
        test_back_to_back();
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_win.size() != 0 || exp_txn.size() != 0) begin
            n_fails++;
            $display("FAIL leftover_expectations got=%0d/%0d exp=0/0", exp_win.size(), exp_txn.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
